// File: rtl/mm_arb_pkg.sv
// Shared arbitration helpers for the MM bridging family.
// rr_pick is written against a fixed maximum width so that any arbiter can call it.
package mm_arb_pkg;

  localparam int MAX_CHANNELS = 64;
  localparam int MAX_CWIDTH   = 6;

  typedef struct packed {
    logic                  found;
    logic [MAX_CWIDTH-1:0] idx;
  } rr_pick_t;

  // Returns the first set bit of req[channels-1:0], searching upward from start
  // and wrapping. The loop runs downward so the smallest offset is the last one
  // written, which avoids an early exit.
  function automatic rr_pick_t rr_pick(input logic [MAX_CHANNELS-1:0] req,
                                       input int                      channels,
                                       input int                      start);
    rr_pick_t res;
    int       pos;
    res = '0;
    for (int k = MAX_CHANNELS - 1; k >= 0; k--) begin
      if (k < channels) begin
        pos = (start + k) % channels;
        if (req[pos[MAX_CWIDTH-1:0]]) begin
          res.found = 1'b1;
          res.idx   = pos[MAX_CWIDTH-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mm_rr_picker.sv
// Combinational round-robin picker: first requester at or after start, with wrap.
// CHANNELS must not exceed mm_arb_pkg::MAX_CHANNELS.
module mm_rr_picker
  import mm_arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  localparam int CWIDTH  = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CWIDTH-1:0]   start,
  output logic                found,
  output logic [CWIDTH-1:0]   idx
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_CHANNELS'(req), CHANNELS, int'(start));
    found = pick.found;
    idx   = pick.idx[CWIDTH-1:0];
  end

endmodule

// File: rtl/mm_rr_arbiter.sv
// Round-robin arbiter connecting CHANNELS MM masters to a single MM slave.
// The grant is held through slave stalls and released on completion or abandon.
module mm_rr_arbiter
  import mm_arb_pkg::*;
#(
  parameter int AWIDTH   = 8,
  parameter int DWIDTH   = 8,
  parameter int CHANNELS = 4,
  localparam int CWIDTH  = $clog2(CHANNELS)
) (
  input  logic                       reset,
  input  logic                       clk,
  input  logic [CHANNELS*AWIDTH-1:0] s_addr,
  input  logic [CHANNELS-1:0]        s_wreq,
  input  logic [CHANNELS*DWIDTH-1:0] s_wdat,
  input  logic [CHANNELS-1:0]        s_rreq,
  output logic [CHANNELS*DWIDTH-1:0] s_rdat,
  output logic [CHANNELS-1:0]        s_busy,
  output logic [AWIDTH-1:0]          m_addr,
  output logic                       m_wreq,
  output logic [DWIDTH-1:0]          m_wdat,
  output logic                       m_rreq,
  input  logic [DWIDTH-1:0]          m_rdat,
  input  logic                       m_busy,
  output logic [CWIDTH-1:0]          m_chan
);

  logic                gvalid_reg;
  logic [CWIDTH-1:0]   grant_reg;
  logic [CWIDTH-1:0]   last_reg;

  logic [CHANNELS-1:0] req;
  logic                cur_req;
  logic                release_grant;
  logic [CWIDTH-1:0]   start;
  logic                pick_found;
  logic [CWIDTH-1:0]   pick_idx;

  function automatic logic [CWIDTH-1:0] next_chan(input logic [CWIDTH-1:0] c);
    return (c == CWIDTH'(CHANNELS - 1)) ? '0 : c + 1'b1;
  endfunction

  assign req = s_wreq | s_rreq;

  // While granted, last_reg is about to become grant_reg, so the search base
  // comes straight from the grant and the current owner lands at lowest priority.
  assign start = gvalid_reg ? next_chan(grant_reg) : next_chan(last_reg);

  mm_rr_picker #(
    .CHANNELS (CHANNELS)
  ) u_picker (
    .req   (req),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // NOTE: every output gets a default before the mux so no latch is inferred.
  always_comb begin
    m_addr  = '0;
    m_wdat  = '0;
    m_wreq  = 1'b0;
    m_rreq  = 1'b0;
    m_chan  = '0;
    s_busy  = '1;
    s_rdat  = '0;
    cur_req = 1'b0;
    if (gvalid_reg) begin
      m_chan = grant_reg;
      for (int i = 0; i < CHANNELS; i++) begin
        if (grant_reg == CWIDTH'(i)) begin
          m_addr                     = s_addr[i*AWIDTH +: AWIDTH];
          m_wdat                     = s_wdat[i*DWIDTH +: DWIDTH];
          m_wreq                     = s_wreq[i];
          m_rreq                     = s_rreq[i];
          s_busy[i]                  = m_busy;
          s_rdat[i*DWIDTH +: DWIDTH] = m_rdat;
          cur_req                    = req[i];
        end
      end
    end
  end

  // Completion and abandon share the same re-arbitration path.
  assign release_grant = gvalid_reg & (~cur_req | ~m_busy);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      gvalid_reg <= 1'b0;
      grant_reg  <= '0;
      last_reg   <= CWIDTH'(CHANNELS - 1);
    end else if (!gvalid_reg) begin
      if (pick_found) begin
        gvalid_reg <= 1'b1;
        grant_reg  <= pick_idx;
      end
    end else if (release_grant) begin
      last_reg   <= grant_reg;
      gvalid_reg <= pick_found;
      if (pick_found) begin
        grant_reg <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_mm_rr_arbiter.sv
// Self-checking bench for mm_rr_arbiter: directed scenarios plus random traffic
// compared every cycle against an owner/last-served reference model.
module tb_mm_rr_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CH = 4;
  localparam int CW = 2;

  logic             reset;
  logic             clk;
  logic [CH*AW-1:0] s_addr;
  logic [CH-1:0]    s_wreq;
  logic [CH*DW-1:0] s_wdat;
  logic [CH-1:0]    s_rreq;
  logic [CH*DW-1:0] s_rdat;
  logic [CH-1:0]    s_busy;
  logic [AW-1:0]    m_addr;
  logic             m_wreq;
  logic [DW-1:0]    m_wdat;
  logic             m_rreq;
  logic [DW-1:0]    m_rdat;
  logic             m_busy;
  logic [CW-1:0]    m_chan;

  mm_rr_arbiter #(
    .AWIDTH   (AW),
    .DWIDTH   (DW),
    .CHANNELS (CH)
  ) dut (
    .reset  (reset),
    .clk    (clk),
    .s_addr (s_addr),
    .s_wreq (s_wreq),
    .s_wdat (s_wdat),
    .s_rreq (s_rreq),
    .s_rdat (s_rdat),
    .s_busy (s_busy),
    .m_addr (m_addr),
    .m_wreq (m_wreq),
    .m_wdat (m_wdat),
    .m_rreq (m_rreq),
    .m_rdat (m_rdat),
    .m_busy (m_busy),
    .m_chan (m_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the slave (-1 = nobody) and who was served last.
  int owner = -1;
  int last  = CH - 1;

  // Values seen in the most recent step, for directed checks.
  logic          o_wreq, o_rreq;
  logic [CW-1:0] o_chan;
  logic [CH-1:0] o_busy;
  logic [31:0]   o_rdat;
  logic [7:0]    o_wdat, o_addr;

  function automatic int rr_first(input logic [CH-1:0] r, input int from);
    for (int k = 0; k < CH; k++) begin
      if (r[(from + k) % CH]) return (from + k) % CH;
    end
    return -1;
  endfunction

  // One clock: drive at the falling edge, check outputs, then advance the model.
  task automatic step(input logic rst, input logic [CH-1:0] wr, input logic [CH-1:0] rd,
                      input logic mb, input logic [7:0] mrd,
                      input logic [31:0] addr, input logic [31:0] wd);
    logic             e_wreq, e_rreq;
    logic [CH-1:0]    e_busy;
    logic [31:0]      e_rdat;
    logic [7:0]       e_addr, e_wdat;
    logic [CW-1:0]    e_chan;
    logic [CH-1:0]    r;
    @(negedge clk);
    reset  = rst;
    s_wreq = wr;
    s_rreq = rd;
    m_busy = mb;
    m_rdat = mrd;
    s_addr = addr;
    s_wdat = wd;
    #1;
    e_wreq = 1'b0; e_rreq = 1'b0; e_busy = '1; e_rdat = '0;
    e_addr = '0;   e_wdat = '0;   e_chan = '0;
    if (owner >= 0) begin
      e_wreq = wr[owner];
      e_rreq = rd[owner];
      e_busy[owner] = mb;
      e_rdat = {24'h0, mrd} << (8 * owner);
      e_addr = 8'((addr >> (8 * owner)) & 32'hFF);
      e_wdat = 8'((wd >> (8 * owner)) & 32'hFF);
      e_chan = CW'(owner);
    end
    check("m_wreq", 64'(m_wreq), 64'(e_wreq));
    check("m_rreq", 64'(m_rreq), 64'(e_rreq));
    check("s_busy", 64'(s_busy), 64'(e_busy));
    check("s_rdat", 64'(s_rdat), 64'(e_rdat));
    if (owner >= 0) begin
      check("m_chan", 64'(m_chan), 64'(e_chan));
      check("m_addr", 64'(m_addr), 64'(e_addr));
      check("m_wdat", 64'(m_wdat), 64'(e_wdat));
    end else begin
      check("idle_out", 64'({m_chan, m_addr, m_wdat}), 64'(0));
    end
    o_wreq = m_wreq; o_rreq = m_rreq; o_chan = m_chan;
    o_busy = s_busy; o_rdat = s_rdat; o_wdat = m_wdat; o_addr = m_addr;
    @(posedge clk);
    r = wr | rd;
    if (rst) begin
      owner = -1;
      last  = CH - 1;
    end else if (owner < 0) begin
      owner = rr_first(r, (last + 1) % CH);
    end else if (!r[owner] || !mb) begin
      last  = owner;
      owner = rr_first(r, (owner + 1) % CH);
    end
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0, 1'b0, 8'h00, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; s_wreq = '0; s_rreq = '0; m_busy = 1'b0; m_rdat = '0;
    s_addr = '0; s_wdat = '0;
    do_reset();
    do_reset();

    // Reset in the middle of a stalled write.
    step(1'b0, 4'b0001, 4'b0000, 1'b1, 8'h00, 32'h0, 32'h0);
    step(1'b0, 4'b0001, 4'b0000, 1'b1, 8'h00, 32'h0, 32'h0);
    check("pre_rst_wreq", 64'(o_wreq), 64'(1));
    step(1'b1, 4'b0001, 4'b0000, 1'b1, 8'h00, 32'h0, 32'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 8'h00, 32'h0, 32'h0);
    check("post_rst_busy", 64'(o_busy), 64'(4'b1111));
    check("post_rst_wreq", 64'(o_wreq), 64'(0));
    step(1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0);
    step(1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0);
    check("first_after_rst", 64'(o_chan), 64'(0));
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0);
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0);

    // Single read on channel 2.
    step(1'b0, 4'b0000, 4'b0100, 1'b0, 8'hA5, 32'h0015_0000, 32'h0);
    check("rd_latency", 64'(o_rreq), 64'(0));
    step(1'b0, 4'b0000, 4'b0100, 1'b0, 8'hA5, 32'h0015_0000, 32'h0);
    check("rd_rreq", 64'(o_rreq), 64'(1));
    check("rd_chan", 64'(o_chan), 64'(2));
    check("rd_addr", 64'(o_addr), 64'(8'h15));
    check("rd_rdat", 64'(o_rdat[23:16]), 64'(8'hA5));
    check("rd_busy2", 64'(o_busy[2]), 64'(0));

    // All channels writing continuously: strict rotation, no gaps.
    do_reset();
    step(1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h4433_2211);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'b1111, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h4433_2211);
      check("rot_chan", 64'(o_chan), 64'(k % CH));
      check("rot_wreq", 64'(o_wreq), 64'(1));
    end

    // Stall on channel 1 holds the grant against channel 3.
    do_reset();
    step(1'b0, 4'b0010, 4'b0000, 1'b1, 8'h00, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b1010, 4'b0000, 1'b1, 8'h00, 32'h0, 32'h0);
      check("stall_chan", 64'(o_chan), 64'(1));
      check("stall_busy3", 64'(o_busy[3]), 64'(1));
    end
    step(1'b0, 4'b1010, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0);
    step(1'b0, 4'b1000, 4'b0000, 1'b1, 8'h00, 32'h0, 32'h0);
    check("stall_next", 64'(o_chan), 64'(3));

    // Channel 0 abandons while channel 2 waits.
    do_reset();
    step(1'b0, 4'b0001, 4'b0000, 1'b1, 8'h00, 32'h0, 32'h0);
    step(1'b0, 4'b0001, 4'b0000, 1'b1, 8'h00, 32'h0, 32'h0);
    check("abn_chan0", 64'(o_chan), 64'(0));
    step(1'b0, 4'b0100, 4'b0000, 1'b1, 8'h00, 32'h0, 32'h0);
    check("abn_noreq", 64'({o_wreq, o_rreq}), 64'(0));
    step(1'b0, 4'b0100, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0);
    check("abn_chan2", 64'(o_chan), 64'(2));
    check("abn_wreq2", 64'(o_wreq), 64'(1));

    // Back-to-back writes from a lone channel 1.
    do_reset();
    step(1'b0, 4'b0010, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0000_1100);
    step(1'b0, 4'b0010, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0000_1100);
    check("b2b_w1", 64'({o_wreq, o_wdat}), 64'({1'b1, 8'h11}));
    step(1'b0, 4'b0010, 4'b0000, 1'b0, 8'h00, 32'h0, 32'h0000_2200);
    check("b2b_w2", 64'({o_wreq, o_wdat}), 64'({1'b1, 8'h22}));

    // Random traffic, including simultaneous read/write and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      logic [CH-1:0] wr, rd;
      wr = CH'($urandom);
      rd = CH'($urandom & $urandom);
      if (n % 500 < 100) begin
        wr = wr & CH'($urandom);
        rd = rd & CH'($urandom);
      end
      step($urandom_range(0, 99) == 0, wr, rd, $urandom_range(0, 2) == 0,
           8'($urandom), $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
